uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter (`uart_tx`, the transmit counterpart of the bus's RS-232 receiver) between `N_REQ` requesters on the bus.
- Accepts one byte per grant over a valid/ready handshake.
- Launches the byte on the transmitter and waits for its completion pulse before granting again.
- Recovers from a hung transmitter via a watchdog.

---
 rtl/uart_tx_arbiter_if.sv | 47 ++++
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester side (valid/ready byte handshake) and the uart_tx side
// (start/done frame handshake) of the round-robin UART transmit arbiter.
//
// Handshakes:
//   requester i: holds req_valid[i] and its byte req_data[8i+7:8i] stable until
//                the one-cycle req_ready[i] pulse; the byte is taken on that pulse.
//   uart_tx:     one-cycle tx_start launches a frame with tx_data, which stays
//                stable until the one-cycle tx_done pulse ends the frame.
//
// Signals:
//   req_valid   [N_REQ]    requester i has a byte pending
//   req_data    [8*N_REQ]  byte of requester i at bits [8i+7:8i]
//   req_ready   [N_REQ]    one-cycle accept pulse per requester
//   tx_start               one-cycle frame start to uart_tx
//   tx_data     [8]        byte being transmitted
//   tx_done                one-cycle frame-finished pulse from uart_tx
//   grant_id    [3]        requester currently / last served
//   busy                   arbiter not idle
//   timeout_err            one-cycle watchdog expiry pulse
//   fsm_state   [3]        debug view of the arbiter state register
//
// Modports: master = arbiter side, slave = requesters + transmitter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;
  logic [2:0]         grant_id;
  logic               busy;
  logic               timeout_err;
  logic [2:0]         fsm_state;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, grant_id, busy, timeout_err, fsm_state
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, busy, timeout_err, fsm_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler sharing one uart_tx between N_REQ requesters. One byte
// is accepted per grant, launched on the transmitter, and the arbiter waits for
// tx_done (or the watchdog) before arbitrating again. The requester just served
// gets the lowest priority on the next arbitration.
//
// Optional feature: define UART_ARB_TAG_EN to precede every data frame with a
// tag frame 8'hA0 | grant_id (states TAG and TAGWAIT).
//
// Parameters:
//   N_REQ    number of requesters, 2..8
//   TIMEOUT  cycles from tx_start to watchdog expiry (must exceed a frame time)
//
// Ports:
//   clock    rising-edge clock
//   resetn   asynchronous active-low reset
//   bus      uart_tx_arbiter_if.master (requester and transmitter handshakes)
//
// All outputs are registers: each output is set on the transition into the
// state in which it must be visible.
module uart_tx_arbiter #(
  parameter int          N_REQ   = 4,
  parameter logic [15:0] TIMEOUT = 16'd60000
) (
  input  logic               clock,
  input  logic               resetn,
  uart_tx_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT    = 3'd3
`ifdef UART_ARB_TAG_EN
    ,
    S_TAG     = 3'd4,
    S_TAGWAIT = 3'd5
`endif
  } state_t;

  state_t      state;
  logic [2:0]  last;
  logic [2:0]  grant;
  logic [7:0]  hold;
  logic [15:0] wd_cnt;

  // Requests and data zero-extended to the 8-requester maximum so a 3-bit
  // index can address them for any legal N_REQ.
  logic [7:0]  valid_ext;
  logic [63:0] data_ext;
  logic        sel_any;
  logic [2:0]  sel_idx;
  logic [3:0]  cand;
  logic [7:0]  sel_byte;
  logic        wd_expire;

  assign valid_ext = 8'(bus.req_valid);
  assign data_ext  = 64'(bus.req_data);
  assign sel_byte  = data_ext[{sel_idx, 3'b000} +: 8];
  assign wd_expire = (wd_cnt >= TIMEOUT - 16'd1);

  // Scan from the farthest candidate (last itself) back to last+1 so the
  // nearest requester after last is the one left selected.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = 3'd0;
    cand    = 4'd0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, last} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (valid_ext[cand[2:0]]) begin
        sel_any = 1'b1;
        sel_idx = cand[2:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      last            <= 3'(N_REQ - 1);
      grant           <= 3'(N_REQ - 1);
      hold            <= 8'h00;
      wd_cnt          <= 16'd0;
      bus.req_ready   <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= 8'h00;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.req_ready   <= '0;
      bus.tx_start    <= 1'b0;
      bus.timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_any) begin
            grant         <= sel_idx;
            hold          <= sel_byte;
            bus.req_ready <= N_REQ'(1) << sel_idx;
            bus.busy      <= 1'b1;
            state         <= S_LOAD;
          end
        end

        S_LOAD: begin
          // The watchdog counts cycles from the tx_start pulse onward.
          bus.tx_start <= 1'b1;
          wd_cnt       <= 16'd0;
`ifdef UART_ARB_TAG_EN
          bus.tx_data  <= 8'hA0 | {5'd0, grant};
          state        <= S_TAG;
`else
          bus.tx_data  <= hold;
          state        <= S_SEND;
`endif
        end

        S_SEND: begin
          wd_cnt <= wd_cnt + 16'd1;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.tx_done) begin
            last     <= grant;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end else if (wd_expire) begin
            // Byte dropped, no retry; counter held at TIMEOUT.
            wd_cnt          <= TIMEOUT;
            bus.timeout_err <= 1'b1;
            last            <= grant;
            bus.busy        <= 1'b0;
            state           <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end

`ifdef UART_ARB_TAG_EN
        S_TAG: begin
          wd_cnt <= wd_cnt + 16'd1;
          state  <= S_TAGWAIT;
        end

        S_TAGWAIT: begin
          if (bus.tx_done) begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= hold;
            wd_cnt       <= 16'd0;
            state        <= S_SEND;
          end else if (wd_expire) begin
            wd_cnt          <= TIMEOUT;
            bus.timeout_err <= 1'b1;
            last            <= grant;
            bus.busy        <= 1'b0;
            state           <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
`endif

        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_id  = grant;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Randomised bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=100). A transaction
// model predicts the winner of each arbitration from the round-robin rule and
// the request mask the bench drives, the latency of ready/start/done and of the
// watchdog, and queues the bytes expected on the transmitter. Define
// UART_ARB_TAG_EN for both the bench and the design to cover the tag frames.
module tb_uart_tx_arbiter;
  localparam int          N  = 4;
  localparam logic [15:0] TO = 16'd100;

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         m_last;
  int         exp_to = 0;
  int         to_seen = 0;
  int         order[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requester after the last served, wrapping.
  function automatic int rr_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Every tx_start must carry the next expected byte.
  always @(negedge clock) begin
    if (resetn && bus.tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("tx_extra", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_data", bus.tx_data, mon_exp);
      end
    end
    if (resetn && bus.timeout_err === 1'b1) to_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [7:0] d);
    bus.req_valid[i]       = v;
    bus.req_data[8*i +: 8] = d;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    exp_q.delete();
    m_last = N - 1;
  endtask

  // Called #1 after a tx_start edge; returns #1 after the edge sampling tx_done.
  task automatic pulse_done(input int d);
    repeat (d - 1) @(posedge clock);
    #1 bus.tx_done = 1'b1;
    @(posedge clock);
    #1 bus.tx_done = 1'b0;
  endtask

  // Called #1 after a tx_start edge; waits for the watchdog pulse.
  task automatic wait_timeout();
    int n;
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < int'(TO) + 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("timeout_latency", n, TO);
    check("busy_after_timeout", bus.busy, 0);
    exp_to++;
  endtask

  // One grant from an idle arbiter. Called #1 after an edge with requests set.
  task automatic do_grant(input int d, input bit to_case, input bit keep, input bit early);
    int g;
    logic [7:0] byte_v;
    g = rr_pick(bus.req_valid, m_last);
    if (g < 0) begin
      check("no_request", 0, 1);
      return;
    end
    byte_v = bus.req_data[8*g +: 8];
    order.push_back(g);
    @(posedge clock);
    #1;
    check("req_ready", bus.req_ready, 32'(1) << g);
    check("grant_id", bus.grant_id, g);
    check("busy_set", bus.busy, 1);
    check("tx_start_early", bus.tx_start, 0);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back(8'hA0 | 8'(g));
`endif
    exp_q.push_back(byte_v);
    if (keep) bus.req_data[8*g +: 8] = 8'($urandom_range(0, 255));
    else      bus.req_valid[g] = 1'b0;
    if (early) bus.tx_done = 1'b1;  // sampled in the accept cycle: must be ignored
    @(posedge clock);
    #1;
    bus.tx_done = 1'b0;
    check("tx_start", bus.tx_start, 1);
    check("req_ready_low", bus.req_ready, 0);
`ifdef UART_ARB_TAG_EN
    if (to_case) begin
      wait_timeout();
      void'(exp_q.pop_back());  // data byte dropped with the tag frame
      m_last = g;
      return;
    end
    pulse_done(d);
    check("data_start_after_tag", bus.tx_start, 1);
    check("busy_between_frames", bus.busy, 1);
`endif
    if (to_case) begin
      wait_timeout();
    end else begin
      pulse_done(d);
      check("busy_clear", bus.busy, 0);
      check("no_timeout", bus.timeout_err, 0);
    end
    m_last = g;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    m_last        = N - 1;
    #12;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_grant_id", bus.grant_id, N - 1);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Single requester 2 with 8'h5A.
    set_req(2, 1'b1, 8'h5A);
    do_grant(10, 1'b0, 1'b0, 1'b0);

    // All four continuously requesting after reset: 0,1,2,3,0,1.
    do_reset();
    order.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'($urandom_range(0, 255)));
    repeat (6) do_grant(10, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) check("rotation", order[i], i % N);
    bus.req_valid = '0;

    // Wrap-around: serve 1, then 1 and 3 together -> 3 then 1.
    set_req(1, 1'b1, 8'h11);
    do_grant(5, 1'b0, 1'b0, 1'b0);
    order.delete();
    set_req(1, 1'b1, 8'h12);
    set_req(3, 1'b1, 8'h33);
    do_grant(4, 1'b0, 1'b1, 1'b0);
    do_grant(4, 1'b0, 1'b1, 1'b0);
    check("wrap_first", order[0], 3);
    check("wrap_second", order[1], 1);
    bus.req_valid = '0;

    // Watchdog: no tx_done, then the next requester is served normally.
    set_req(0, 1'b1, 8'hC3);
    do_grant(0, 1'b1, 1'b0, 1'b0);
    set_req(2, 1'b1, 8'h7E);
    do_grant(10, 1'b0, 1'b0, 1'b0);

    // tx_done while idle is ignored.
    #1 bus.tx_done = 1'b1;
    @(posedge clock);
    #1 bus.tx_done = 1'b0;
    @(posedge clock);
    #1;
    check("idle_done_busy", bus.busy, 0);
    check("idle_done_ready", bus.req_ready, 0);

    // Randomised grants.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'b1, 8'($urandom_range(0, 255)));
      end
      if (bus.req_valid == '0) set_req($urandom_range(0, N - 1), 1'b1, 8'($urandom_range(0, 255)));
      do_grant($urandom_range(2, 20), ($urandom_range(0, 7) == 0),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a frame, just after tx_start.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'($urandom_range(0, 255)));
    @(posedge clock);
    @(posedge clock);
    #1;
    check("pre_reset_start", bus.tx_start, 1);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_tx_start", bus.tx_start, 0);
    check("mid_rst_tx_data", bus.tx_data, 0);
    check("mid_rst_grant_id", bus.grant_id, N - 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_timeout_err", bus.timeout_err, 0);
    resetn = 1'b1;
    exp_q.delete();
    m_last = N - 1;
    order.delete();
    do_grant(10, 1'b0, 1'b1, 1'b0);
    check("after_reset_grant", order[0], 0);
    bus.req_valid = '0;

    repeat (3) @(posedge clock);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("timeout_pulses", to_seen, exp_to);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
